// File: rtl/typePack.sv
// ============================================================================
// Module  : typePack
// Purpose : Shared fetch-path types and constants.
// Revision: 1.0
// ============================================================================
`default_nettype none

package typePack;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] instruction_t;

    // addi x0,x0,0
    localparam instruction_t INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        instruction_t    inst;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module  : fetch_fifo
// Purpose : Power-of-two synchronous FIFO with flush and occupancy count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module  : inst_fetch
// Purpose : Fetch PC owner, credit-limited memory reads, in-order buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_fetch
    import typePack::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         CLOCK,
    input  logic         RESET_N,
    input  logic         REDIRECT,
    input  logic [31:0]  REDIRECT_PC,
    output instruction_t INST,
    output logic [31:0]  INST_PC,
    output logic         INST_VALID,
    input  logic         INST_READY,
    output logic         MEM_REQ,
    output logic [31:0]  MEM_ADDR,
    input  logic         MEM_GNT,
    input  logic         MEM_RVALID,
    input  logic [31:0]  MEM_RDATA
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic          running;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [CW:0]   in_use;
    logic [31:0]   resp_pc;
    logic          grant;
    logic          resp;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^REDIRECT_PC[1:0];

    // Discarded in-flight reads still hold credit until they return.
    assign in_use   = {1'b0, outstanding} + {1'b0, count};
    assign MEM_REQ  = running && (in_use < (CW+1)'(DEPTH));
    assign MEM_ADDR = fetch_pc;

    assign grant = MEM_REQ && MEM_GNT;
    assign resp  = MEM_RVALID && (outstanding != '0);
    assign push  = resp && (discard == '0);
    assign pop   = INST_VALID && INST_READY;

    assign outstanding_next = outstanding + CW'(grant) - CW'(resp);

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = resp_pc;
        push_entry.inst = MEM_RDATA;
    end

    // The tag queue's occupancy is the outstanding-read count.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk       (CLOCK),
        .rst_n     (RESET_N),
        .flush     (1'b0),
        .push      (grant),
        .push_data (fetch_pc),
        .pop       (resp),
        .head      (resp_pc),
        .count     (outstanding)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk       (CLOCK),
        .rst_n     (RESET_N),
        .flush     (REDIRECT),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (count)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            fetch_pc <= RESET_PC;
            running  <= 1'b0;
            discard  <= '0;
        end else begin
            running <= 1'b1;
            if (REDIRECT) begin
                fetch_pc <= {REDIRECT_PC[31:2], 2'b00};
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (REDIRECT) begin
                discard <= outstanding_next;
            end else if (resp && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
        end
    end

    assign INST_VALID = (count != '0);
    assign INST       = INST_VALID ? head_entry.inst : INST_NOP;
    assign INST_PC    = INST_VALID ? head_entry.pc   : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module  : tb_inst_fetch
// Purpose : Directed and randomised checks of inst_fetch against a stream model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch;
    import typePack::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PAT      = 32'hA5A5_0000;

    logic         clk = 1'b0;
    logic         RESET_N;
    logic         REDIRECT;
    logic [31:0]  REDIRECT_PC;
    instruction_t INST;
    logic [31:0]  INST_PC;
    logic         INST_VALID;
    logic         INST_READY;
    logic         MEM_REQ;
    logic [31:0]  MEM_ADDR;
    logic         MEM_GNT;
    logic         MEM_RVALID;
    logic [31:0]  MEM_RDATA;

    always #5 clk = ~clk;

    inst_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLOCK       (clk),
        .RESET_N     (RESET_N),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .INST        (INST),
        .INST_PC     (INST_PC),
        .INST_VALID  (INST_VALID),
        .INST_READY  (INST_READY),
        .MEM_REQ     (MEM_REQ),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_GNT     (MEM_GNT),
        .MEM_RVALID  (MEM_RVALID),
        .MEM_RDATA   (MEM_RDATA)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rd_t;

    rd_t         pend[$];
    logic [31:0] log_pc[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          gnt_mode = 0;
    int          k_min = 1;
    int          k_max = 1;
    int          ready_mode = 1;
    int          redir_rate = 0;
    int          coinc_mode = 0;
    bit          coinc_hit = 0;
    bit          redir_req = 0;
    logic [31:0] redir_pc = 32'h0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_req = RESET_PC;
    logic [31:0] prev_pc = 32'h0;
    bit          prev_valid = 0;
    bit          saw_wrap = 0;
    int          last_due = 0;
    int          n_deliv = 0;
    int          n_grant = 0;
    int          tick_no = 0;
    int          first_deliv_tick = -1;
    logic        obs_valid = 1'b0;
    logic        obs_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // One bus cycle: observe at negedge, drive the next edge's inputs, update model.
    task automatic tick();
        logic        v, rq, g, rv, rd;
        logic [31:0] ipc, inst, addr, npc;
        int          k, due;
        @(negedge clk);
        v = INST_VALID; rq = MEM_REQ; ipc = INST_PC; inst = INST; addr = MEM_ADDR;
        obs_valid = v;
        obs_req   = rq;
        rv = (pend.size() > 0) && (pend[0].due <= cyc + 1);
        MEM_RVALID = rv;
        MEM_RDATA  = rv ? (pend[0].addr ^ PAT) : 32'h0;
        if (rv) void'(pend.pop_front());
        g = (gnt_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        MEM_GNT = g;
        INST_READY = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode != 0);
        rd = v && INST_READY;
        if (coinc_mode == 1 && rv && rq && g) begin
            redir_req = 1; redir_pc = 32'h0000_0200; coinc_hit = 1; coinc_mode = 0;
        end else if (coinc_mode == 2 && rv && rd) begin
            redir_req = 1; redir_pc = 32'h0000_0300; coinc_hit = 1; coinc_mode = 0;
        end else if (redir_rate != 0 && $urandom_range(0, redir_rate - 1) == 0) begin
            redir_req = 1;
            case ($urandom_range(0, 2))
                0:       redir_pc = 32'hFFFF_FFFD;
                1:       redir_pc = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
                default: redir_pc = $urandom();
            endcase
        end
        REDIRECT    = redir_req;
        REDIRECT_PC = redir_pc;
        redir_req   = 0;
        if (rd) begin
            checks++;
            if (ipc !== exp_pc || inst !== (exp_pc ^ PAT)) begin
                failures++;
                $display("FAIL deliver: INST_PC=%h INST=%h required pc=%h inst=%h",
                         ipc, inst, exp_pc, exp_pc ^ PAT);
            end
            if (prev_valid && prev_pc == 32'hFFFF_FFFC && ipc == 32'h0) saw_wrap = 1;
            prev_pc = ipc; prev_valid = 1;
            log_pc.push_back(ipc);
            n_deliv++;
            if (first_deliv_tick < 0) first_deliv_tick = tick_no;
            exp_pc = exp_pc + 32'd4;
        end
        if (rq && g) begin
            checks++;
            if (addr !== exp_req || pend.size() >= DEPTH) begin
                failures++;
                $display("FAIL grant: MEM_ADDR=%h in_flight=%0d required addr=%h in_flight<%0d",
                         addr, pend.size(), exp_req, DEPTH);
            end
            k   = $urandom_range(k_min, k_max);
            due = cyc + 1 + k;
            if (due <= last_due) due = last_due + 1;
            pend.push_back('{addr: addr, due: due});
            last_due = due;
            exp_req  = exp_req + 32'd4;
            n_grant++;
        end
        if (REDIRECT) begin
            npc = {REDIRECT_PC[31:2], 2'b00};
            exp_pc = npc; exp_req = npc; prev_valid = 0;
        end
        tick_no++;
        @(posedge clk);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; INST_READY = 1'b0;
        MEM_GNT = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (MEM_REQ !== 1'b0 || MEM_ADDR !== RESET_PC) begin
            failures++;
            $display("FAIL reset_req: MEM_REQ=%b MEM_ADDR=%h required 0 %h", MEM_REQ, MEM_ADDR, RESET_PC);
        end
        checks++;
        if (INST_VALID !== 1'b0 || INST !== INST_NOP || INST_PC !== 32'h0) begin
            failures++;
            $display("FAIL reset_inst: VALID=%b INST=%h PC=%h required 0 %h 0",
                     INST_VALID, INST, INST_PC, INST_NOP);
        end
        RESET_N = 1'b1;
        @(negedge clk);
        checks++;
        if (MEM_REQ !== 1'b1 || MEM_ADDR !== RESET_PC) begin
            failures++;
            $display("FAIL first_req: MEM_REQ=%b MEM_ADDR=%h required 1 %h", MEM_REQ, MEM_ADDR, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int base_tick, base_deliv;
        gnt_mode = 0; k_min = 1; k_max = 1; ready_mode = 1;
        base_tick = tick_no; base_deliv = n_deliv; first_deliv_tick = -1;
        repeat (22) tick();
        checks++;
        if (first_deliv_tick - base_tick != 2) begin
            failures++;
            $display("FAIL first_latency: first delivery in tick %0d required tick 3",
                     first_deliv_tick - base_tick + 1);
        end
        checks++;
        if (n_deliv - base_deliv < 10) begin
            failures++;
            $display("FAIL stream_progress: delivered=%0d required>=10", n_deliv - base_deliv);
        end
    endtask

    task automatic test_stall();
        int g0, d0;
        ready_mode = 0; g0 = n_grant;
        repeat (10) tick();
        checks++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b1 || pend.size() != 0 || n_grant - g0 > 2) begin
            failures++;
            $display("FAIL stall: MEM_REQ=%b VALID=%b in_flight=%0d grants=%0d required 0 1 0 <=2",
                     obs_req, obs_valid, pend.size(), n_grant - g0);
        end
        ready_mode = 1; d0 = n_deliv;
        repeat (20) tick();
        checks++;
        if (n_deliv - d0 < 8) begin
            failures++;
            $display("FAIL stall_resume: delivered=%0d required>=8", n_deliv - d0);
        end
    endtask

    task automatic test_redirect();
        int n;
        gnt_mode = 0; k_min = 3; k_max = 3; ready_mode = 1;
        n = 0;
        while (pend.size() != DEPTH && n < 20) begin tick(); n++; end
        checks++;
        if (pend.size() != DEPTH) begin
            failures++;
            $display("FAIL redirect_setup: in_flight=%0d required %0d", pend.size(), DEPTH);
        end
        redir_req = 1; redir_pc = 32'h0000_0100;
        tick();
        log_pc.delete();
        n = 0;
        while (log_pc.size() < 2 && n < 40) begin tick(); n++; end
        checks++;
        if (log_pc.size() < 2 || log_pc[0] !== 32'h100 || log_pc[1] !== 32'h104) begin
            failures++;
            $display("FAIL redirect_stream: got %0d pcs first=%h required 100,104",
                     log_pc.size(), (log_pc.size() > 0) ? log_pc[0] : 32'hx);
        end
    endtask

    task automatic test_coincident(input int mode, input logic [31:0] target);
        int n;
        gnt_mode = 0; k_min = 1; k_max = 1; ready_mode = 1;
        coinc_hit = 0; coinc_mode = mode;
        n = 0;
        while (!coinc_hit && n < 30) begin tick(); n++; end
        coinc_mode = 0;
        tick();
        checks++;
        if (!coinc_hit || obs_valid !== 1'b0) begin
            failures++;
            $display("FAIL coincident_%0d: hit=%0d INST_VALID=%b required 1 0", mode, coinc_hit, obs_valid);
        end
        log_pc.delete();
        n = 0;
        while (log_pc.size() < 2 && n < 40) begin tick(); n++; end
        checks++;
        if (log_pc.size() < 2 || log_pc[0] !== target || log_pc[1] !== target + 32'd4) begin
            failures++;
            $display("FAIL coincident_stream_%0d: got %0d pcs first=%h required %h",
                     mode, log_pc.size(), (log_pc.size() > 0) ? log_pc[0] : 32'hx, target);
        end
    endtask

    task automatic test_random();
        int d0, n;
        gnt_mode = 1; k_min = 1; k_max = 4; ready_mode = 2; redir_rate = 16;
        d0 = n_deliv;
        repeat (600) tick();
        redir_rate = 0;
        checks++;
        if (n_deliv - d0 < 50) begin
            failures++;
            $display("FAIL random_progress: delivered=%0d required>=50", n_deliv - d0);
        end
        ready_mode = 1; saw_wrap = 0;
        redir_req = 1; redir_pc = 32'hFFFF_FFFF;
        tick();
        n = 0;
        while (!saw_wrap && n < 80) begin tick(); n++; end
        checks++;
        if (!saw_wrap) begin
            failures++;
            $display("FAIL pc_wrap: saw_wrap=%0d required 1", saw_wrap);
        end
    endtask

    task automatic test_reset_mid();
        int n, d0;
        gnt_mode = 0; k_min = 3; k_max = 3; ready_mode = 1;
        n = 0;
        while (pend.size() != DEPTH && n < 20) begin tick(); n++; end
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if (pend.size() != DEPTH || INST_VALID !== 1'b0 || INST !== INST_NOP || INST_PC !== 32'h0 ||
            MEM_REQ !== 1'b0 || MEM_ADDR !== RESET_PC) begin
            failures++;
            $display("FAIL reset_mid: in_flight=%0d VALID=%b INST=%h PC=%h REQ=%b ADDR=%h required %0d 0 %h 0 0 %h",
                     pend.size(), INST_VALID, INST, INST_PC, MEM_REQ, MEM_ADDR, DEPTH, INST_NOP, RESET_PC);
        end
        @(negedge clk);
        REDIRECT = 1'b0; MEM_GNT = 1'b1; INST_READY = 1'b1;
        MEM_RVALID = 1'b1; MEM_RDATA = pend[0].addr ^ PAT;
        @(negedge clk);
        RESET_N = 1'b1;
        MEM_RVALID = 1'b1; MEM_RDATA = pend[1].addr ^ PAT;
        pend.delete();
        exp_pc = RESET_PC; exp_req = RESET_PC; last_due = 0; prev_valid = 0;
        log_pc.delete();
        d0 = n_deliv; n = 0;
        while (n_deliv - d0 < 4 && n < 40) begin tick(); n++; end
        checks++;
        if (log_pc.size() < 4 || log_pc[0] !== RESET_PC || log_pc[3] !== RESET_PC + 32'd12) begin
            failures++;
            $display("FAIL reset_restart: got %0d pcs first=%h required %h",
                     log_pc.size(), (log_pc.size() > 0) ? log_pc[0] : 32'hx, RESET_PC);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_coincident(1, 32'h0000_0200);
        test_coincident(2, 32'h0000_0300);
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
